downcounter_ld: RTL and testbench

DOWNCOUNTER_LD -- requirements
Module: downcounter_ld

---
 rtl/downcounter_ld_pkg.sv | 18 +
 rtl/downcounter_ld_flopr_en.sv | 27 ++
 rtl/downcounter_ld.sv | 74 +++++++
 tb/tb_downcounter_ld.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/downcounter_ld_pkg.sv
// Shared counter definitions for downcounter_ld: state encoding and state type.
// Optional periodic reload is selected with the DOWNCOUNTER_LD_RELOAD_EN macro.
`ifndef DOWNCOUNTER_LD_PKG_SV
`define DOWNCOUNTER_LD_PKG_SV

package downcounter_ld_pkg;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    typedef enum logic {
        ST_IDLE = STATE_IDLE,
        ST_RUN  = STATE_RUN
    } state_t;

endpackage

`endif

// File: rtl/downcounter_ld_flopr_en.sv
// Resettable enabled register with synchronous clear; holds the counter reload value.
module flopr_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_sclr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_sclr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/downcounter_ld.sv
// Loadable down-counter with one-cycle terminal-count pulse and IDLE/RUN state.
// Define DOWNCOUNTER_LD_RELOAD_EN for periodic reload; default build is one-shot.
module downcounter_ld
    import downcounter_ld_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_sclr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_busy
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic [WIDTH-1:0] w_reload;

    flopr_en #(
        .WIDTH (WIDTH)
    ) u_reload (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_sclr  (i_sclr),
        .i_en    (i_load),
        .i_d     (i_load_val),
        .o_q     (w_reload)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (i_sclr) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (i_load) begin
                r_cnt   <= i_load_val;
                r_state <= (i_load_val != '0) ? ST_RUN : ST_IDLE;
            end else if ((r_state == ST_RUN) && i_en) begin
                if (r_cnt > CNT_ONE) begin
                    r_cnt <= r_cnt - CNT_ONE;
                end else if (r_cnt == CNT_ONE) begin
                    r_tc <= 1'b1;
`ifdef DOWNCOUNTER_LD_RELOAD_EN
                    r_cnt   <= w_reload;
`else
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
`endif
                end else begin
                    // RUN at zero cannot arise from legal commands; recover from the reload value
                    r_cnt   <= w_reload;
                    r_state <= (w_reload != '0) ? ST_RUN : ST_IDLE;
                end
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_tc   = r_tc;
    assign o_busy = (r_state == ST_RUN);

endmodule

// File: tb/tb_downcounter_ld.sv
// Self-checking bench for downcounter_ld (WIDTH=4), one-shot or DOWNCOUNTER_LD_RELOAD_EN build.
module tb_downcounter_ld;

  localparam int WIDTH = 4;

  logic             clk;
  logic             i_rst_n;
  logic             i_sclr;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic             i_en;
  logic [WIDTH-1:0] o_cnt;
  logic             o_tc;
  logic             o_busy;

  // expected word layout: {busy, tc, cnt[3:0]}
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  downcounter_ld #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_sclr     (i_sclr),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .i_en       (i_en),
    .o_cnt      (o_cnt),
    .o_tc       (o_tc),
    .o_busy     (o_busy)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus word layout: {sclr, load, en, val[3:0]}; returns 1 ns after the edge
  task automatic drive_cycle(input logic [6:0] stim);
    i_sclr     = stim[6];
    i_load     = stim[5];
    i_en       = stim[4];
    i_load_val = stim[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    logic [5:0] exp;
    i_rst_n = 1'b0; i_sclr = 1'b0; i_load = 1'b0; i_en = 1'b0; i_load_val = '0;
    #3;
    exp_q.push_back(6'b0_0_0000);
    got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL reset_init got=%b expected=%b", got, exp); else n_pass++;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    // load 5 then hold, then assert reset between edges
    exp_q.push_back(6'b1_0_0101);
    drive_cycle(7'b0_1_0_0101);
    got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL reset_load5 got=%b expected=%b", got, exp); else n_pass++;
    #2;
    i_rst_n = 1'b0;
    #1;
    exp_q.push_back(6'b0_0_0000);
    got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL reset_async got=%b expected=%b", got, exp); else n_pass++;
    #2;
    i_rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(6'b0_0_0000);
      drive_cycle(7'b0_0_1_0000);
      got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL reset_after[%0d] got=%b expected=%b", i, got, exp); else n_pass++;
    end
  endtask

`ifndef DOWNCOUNTER_LD_RELOAD_EN
  task automatic test_oneshot();
    logic [6:0] stim [6] = '{7'b0_1_1_0011, 7'b0_0_1_0000, 7'b0_0_1_0000,
                             7'b0_0_1_0000, 7'b0_0_1_0000, 7'b0_0_1_0000};
    logic [5:0] expv [6] = '{6'b1_0_0011, 6'b1_0_0010, 6'b1_0_0001,
                             6'b0_1_0000, 6'b0_0_0000, 6'b0_0_0000};
    logic [5:0] got;
    logic [5:0] exp;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(expv[i]);
      drive_cycle(stim[i]);
      got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL oneshot[%0d] got=%b expected=%b", i, got, exp); else n_pass++;
    end
  endtask
`else
  task automatic test_periodic();
    logic [5:0] expv [10] = '{6'b1_0_0011, 6'b1_0_0010, 6'b1_0_0001, 6'b1_1_0011, 6'b1_0_0010,
                              6'b1_0_0001, 6'b1_1_0011, 6'b1_0_0010, 6'b1_0_0001, 6'b1_1_0011};
    logic [5:0] got;
    logic [5:0] exp;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(expv[i]);
      drive_cycle((i == 0) ? 7'b0_1_1_0011 : 7'b0_0_1_0000);
      got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL periodic[%0d] got=%b expected=%b", i, got, exp); else n_pass++;
    end
    exp_q.push_back(6'b0_0_0000);
    drive_cycle(7'b1_0_0_0000);
    got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) $display("FAIL periodic_sclr got=%b expected=%b", got, exp); else n_pass++;
  endtask
`endif

  task automatic test_enable_gaps();
    logic [6:0] stim [6] = '{7'b0_1_0_0010, 7'b0_0_1_0000, 7'b0_0_0_0000,
                             7'b0_0_0_0000, 7'b0_0_1_0000, 7'b1_0_0_0000};
`ifdef DOWNCOUNTER_LD_RELOAD_EN
    logic [5:0] expv [6] = '{6'b1_0_0010, 6'b1_0_0001, 6'b1_0_0001,
                             6'b1_0_0001, 6'b1_1_0010, 6'b0_0_0000};
`else
    logic [5:0] expv [6] = '{6'b1_0_0010, 6'b1_0_0001, 6'b1_0_0001,
                             6'b1_0_0001, 6'b0_1_0000, 6'b0_0_0000};
`endif
    logic [5:0] got;
    logic [5:0] exp;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(expv[i]);
      drive_cycle(stim[i]);
      got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL gaps[%0d] got=%b expected=%b", i, got, exp); else n_pass++;
    end
  endtask

  task automatic test_priority();
    logic [6:0] stim [7] = '{7'b0_1_0_0010, 7'b0_0_1_0000, 7'b1_1_1_0111, 7'b0_1_1_0111,
                             7'b0_0_0_0000, 7'b0_0_1_0000, 7'b1_0_0_0000};
    logic [5:0] expv [7] = '{6'b1_0_0010, 6'b1_0_0001, 6'b0_0_0000, 6'b1_0_0111,
                             6'b1_0_0111, 6'b1_0_0110, 6'b0_0_0000};
    logic [5:0] got;
    logic [5:0] exp;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(expv[i]);
      drive_cycle(stim[i]);
      got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL priority[%0d] got=%b expected=%b", i, got, exp); else n_pass++;
    end
  endtask

  task automatic test_zero_load();
    logic [5:0] got;
    logic [5:0] exp;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(6'b0_0_0000);
      drive_cycle((i == 0) ? 7'b0_1_1_0000 : 7'b0_0_1_0000);
      got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL zero_load[%0d] got=%b expected=%b", i, got, exp); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] stim [8] = '{7'b0_1_0_0101, 7'b0_0_1_0000, 7'b0_1_1_1001, 7'b0_0_1_0000,
                             7'b0_1_1_0001, 7'b0_0_1_0000, 7'b0_0_1_0000, 7'b1_0_0_0000};
`ifdef DOWNCOUNTER_LD_RELOAD_EN
    logic [5:0] expv [8] = '{6'b1_0_0101, 6'b1_0_0100, 6'b1_0_1001, 6'b1_0_1000,
                             6'b1_0_0001, 6'b1_1_0001, 6'b1_1_0001, 6'b0_0_0000};
`else
    logic [5:0] expv [8] = '{6'b1_0_0101, 6'b1_0_0100, 6'b1_0_1001, 6'b1_0_1000,
                             6'b1_0_0001, 6'b0_1_0000, 6'b0_0_0000, 6'b0_0_0000};
`endif
    logic [5:0] got;
    logic [5:0] exp;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(expv[i]);
      drive_cycle(stim[i]);
      got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL back_to_back[%0d] got=%b expected=%b", i, got, exp); else n_pass++;
    end
  endtask

  task automatic test_random_idle_load();
    logic [5:0] got;
    logic [5:0] exp;
    logic [3:0] val;
    for (int i = 0; i < 6; i++) begin
      val = 4'($urandom_range(1, 15));
      exp_q.push_back({1'b1, 1'b0, val});
      drive_cycle({3'b0_1_1, val});
      got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL rand_load[%0d] got=%b expected=%b", i, got, exp); else n_pass++;
      exp_q.push_back(6'b0_0_0000);
      drive_cycle(7'b1_0_1_0000);
      got = {o_busy, o_tc, o_cnt}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL rand_clear[%0d] got=%b expected=%b", i, got, exp); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
`ifdef DOWNCOUNTER_LD_RELOAD_EN
    test_periodic();
`else
    test_oneshot();
`endif
    test_enable_gaps();
    test_priority();
    test_zero_load();
    test_back_to_back();
    test_random_idle_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
